multicycle_cu: RTL
==================

// Module: multicycle_cu
// PURPOSE
//  Multi-cycle control unit for the ARM-subset processor. It replaces the single-cycle combinational decoder.
//  A Moore FSM sequences fetch/decode/execute/writeback over several clocks from the instruction-register fields.
//  It adds a req/ready memory handshake with a wait-timeout that drops into a sticky FAULT state.
//  It sits between the instruction register, condition-check logic and the multicycle datapath.
// PARAMETERS
//  ALU_CTRL_W  4   alu_control width (>=4); 4-bit opcode zero-extended
//  RD_W        4   register index width
//  PC_REG      15  register index that denotes the PC
//  MAX_WAIT    15  max cycles mem_req may stay unanswered before FAULT (>=1)
// PORTS
//  clk          in   1           clock, rising edge
//  rst          in   1           synchronous, active-high reset
//  op           in   2           instr[27:26]: 00 DP, 01 MEM, 10 BRANCH, 11 illegal
//  funct        in   6           instr[25:20]: [5]=I, [4:1]=cmd (DP) / [3]=U (MEM), [0]=S or L
//  sh_imm       in   1           1 = shift amount is an immediate
//  rd           in   RD_W        destination register
//  cond_ex      in   1           condition passed (from cond logic, valid from DECODE on)
//  mem_ready    in   1           memory completes the current access this cycle
//  mem_req      out  1           memory access request
//  mem_write    out  1           store strobe (only while mem_req)
//  adr_src      out  1           0 = PC address, 1 = ALU result address
//  ir_write     out  1           load instruction register
//  pc_write     out  1           update PC
//  reg_write    out  1           register-file write
//  alu_src_a    out  1           0 = reg A, 1 = PC
//  alu_src_b    out  2           00 reg B, 01 ext imm, 10 constant 4
//  result_src   out  2           00 ALUOut, 01 ReadData, 10 ALU result
//  imm_src      out  2           00 DP imm8, 01 MEM imm12, 10 branch imm24
//  reg_src      out  2           [0] branch (Rn=PC), [1] store (Rm=Rd)
//  flag_write   out  2           [1] NZ, [0] CV
//  alu_control  out  ALU_CTRL_W  ALU operation
//  no_write     out  1           CMP/CMN/TST/TEQ: suppress Rd write
//  sh_src       out  1           MOV/MVN shift path selected
//  fault        out  1           sticky bus-timeout / illegal-op flag
//  state_o      out  4           current state encoding (debug)
// BEHAVIOUR
//  States: FETCH=0 DECODE=1 MEMADR=2 MEMRD=3 MEMWB=4 MEMWR=5 EXECR=6 EXECI=7 ALUWB=8 BRANCH=9 FAULT=10.
//  rst: state<=FETCH, wait_cnt<=0, fault<=0. All strobes are 0 while rst=1; Moore outputs resume the cycle after.
//  FETCH: mem_req=1, adr_src=0, alu_src_a=1, alu_src_b=10, result_src=10.
//    On mem_ready: ir_write=1, pc_write=1, go to DECODE. Otherwise hold.
//  DECODE: alu_src_a=1, alu_src_b=10 (PC+8).
//    op=01 -> MEMADR; op=10 -> BRANCH; op=00 & I -> EXECI; op=00 & ~I -> EXECR; op=11 -> FAULT.
//  MEMADR: alu_src_b=01, imm_src=01, alu_control = U ? ADD(0100) : SUB(0010).
//    If ~cond_ex -> FETCH; else L -> MEMRD, ~L -> MEMWR.
//  MEMRD: mem_req=1, adr_src=1. Go to MEMWB on mem_ready.
//  MEMWR: mem_req=1, mem_write=1, adr_src=1, reg_src[1]=1. Go to FETCH on mem_ready.
//  MEMWB: result_src=01, then FETCH. rd==PC_REG -> pc_write=1, reg_write=0; else reg_write=1.
//  EXECR: alu_control=cmd. alu_src_b=00, except MOV/MVN with sh_imm=1 where alu_src_b=01.
//  EXECI: alu_control=cmd, alu_src_b=01, imm_src=00.
//  EXECR and EXECI then go to ALUWB.
//  In EXECR/EXECI:
//    flag_write[1] = S & cond_ex.
//    flag_write[0] = S & cond_ex & cmd in {ADD,ADC,SUB,SBC,RSB,RSC,CMP,CMN}.
//  ALUWB: result_src=00, then FETCH.
//    If no_write or ~cond_ex: no writes.
//    Else rd==PC_REG -> pc_write=1; else reg_write=1.
//  BRANCH: imm_src=10, reg_src[0]=1, alu_src_b=01, alu_control=ADD, result_src=10, pc_write=cond_ex, then FETCH.
//  no_write = DP & cmd in {1000,1001,1010,1011}. sh_src = DP & cmd in {1101,1111}; valid from DECODE to ALUWB.
//  alu_control holds ADD in all states not listed above.
//  wait_cnt: cleared on entering a mem_req state and on mem_ready; +1 each cycle mem_req=1 & ~mem_ready.
//    Reaching MAX_WAIT with mem_ready=0 -> FAULT. mem_ready in the same cycle wins.
//  FAULT: all strobes 0, fault=1. Exits only via rst.
//  mem_ready while mem_req=0 is ignored.
//  rst mid-access: state goes to FETCH and the pending request is dropped.
// TESTING
//  T1 rst, ADD R1,R2,R3 (op=00,funct=001000), ready same cycle -> FETCH,DECODE,EXECR,ALUWB; reg_write=1 in ALUWB; 4 cycles.
//  T2 LDR (op=01,funct=011001), ready after 3 waits in MEMRD -> MEMRD held 4 cycles; MEMWB result_src=01, reg_write=1.
//  T3 SUBS R15 with cond_ex=1 -> ALUWB pc_write=1, reg_write=0; EXEC flag_write=11. CMP -> no_write=1, no reg_write.
//  T4 B with cond_ex=0 -> BRANCH pc_write=0. STR with cond_ex=0 -> MEMADR goes to FETCH, mem_write never 1.
//  T5 FETCH with mem_ready held 0 (MAX_WAIT=15) -> FAULT after 15 cycles; ready on cycle 15 -> DECODE, no fault.
//  T6 op=11 -> FAULT sticky through 20 cycles; rst mid-MEMWR -> FETCH next cycle, fault=0.

Source files
------------

// File: rtl/multicycle_cu.sv
// rtl/multicycle_cu.sv - multi-cycle control unit for the ARM-subset processor
//
// Purpose
//   Moore FSM that sequences fetch / decode / execute / writeback over several
//   clocks from the instruction-register fields. Memory accesses use a
//   req/ready handshake; a request left unanswered for MAX_WAIT cycles drops
//   the unit into a sticky FAULT state that only rst leaves. An illegal
//   opcode (op=11) also lands in FAULT.
//
// Ports
//   clk, rst                  clock (rising edge), synchronous active-high reset
//   op, funct, sh_imm, rd     instruction-register fields
//   cond_ex                   condition passed (valid from DECODE on)
//   mem_ready                 memory completes the current access this cycle
//   mem_req, mem_write        memory request / store strobe
//   adr_src                   0 = PC address, 1 = ALU result address
//   ir_write, pc_write        instruction-register load, PC update
//   reg_write                 register-file write
//   alu_src_a, alu_src_b      ALU operand selects
//   result_src, imm_src       result mux, immediate extension select
//   reg_src                   [0] Rn=PC (branch), [1] Rm=Rd (store)
//   flag_write                [1] NZ, [0] CV
//   alu_control               ALU operation
//   no_write, sh_src          compare-class / MOV-MVN decode flags
//   fault                     sticky timeout / illegal-op flag
//   state_o                   current state encoding

module multicycle_cu #(
    parameter int ALU_CTRL_W = 4,
    parameter int RD_W       = 4,
    parameter int PC_REG     = 15,
    parameter int MAX_WAIT   = 15
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic [1:0]            op,
    input  logic [5:0]            funct,
    input  logic                  sh_imm,
    input  logic [RD_W-1:0]       rd,
    input  logic                  cond_ex,
    input  logic                  mem_ready,
    output logic                  mem_req,
    output logic                  mem_write,
    output logic                  adr_src,
    output logic                  ir_write,
    output logic                  pc_write,
    output logic                  reg_write,
    output logic                  alu_src_a,
    output logic [1:0]            alu_src_b,
    output logic [1:0]            result_src,
    output logic [1:0]            imm_src,
    output logic [1:0]            reg_src,
    output logic [1:0]            flag_write,
    output logic [ALU_CTRL_W-1:0] alu_control,
    output logic                  no_write,
    output logic                  sh_src,
    output logic                  fault,
    output logic [3:0]            state_o
);

    typedef enum logic [3:0] {
        S_FETCH  = 4'd0,
        S_DECODE = 4'd1,
        S_MEMADR = 4'd2,
        S_MEMRD  = 4'd3,
        S_MEMWB  = 4'd4,
        S_MEMWR  = 4'd5,
        S_EXECR  = 4'd6,
        S_EXECI  = 4'd7,
        S_ALUWB  = 4'd8,
        S_BRANCH = 4'd9,
        S_FAULT  = 4'd10
    } state_t;

    localparam int CNT_W = $clog2(MAX_WAIT + 1);

    localparam logic [ALU_CTRL_W-1:0] ALU_ADD = ALU_CTRL_W'(4'b0100);
    localparam logic [ALU_CTRL_W-1:0] ALU_SUB = ALU_CTRL_W'(4'b0010);

    state_t           r_state;
    state_t           w_next;
    logic [CNT_W-1:0] r_wait_cnt;
    logic             r_fault;

    // Instruction field decode
    logic       w_is_dp;
    logic       w_imm;
    logic [3:0] w_cmd;
    logic       w_s;
    logic       w_u;
    logic       w_l;
    logic       w_rd_is_pc;
    logic       w_no_write_dec;
    logic       w_sh_src_dec;
    logic       w_arith;
    logic [1:0] w_flags;

    assign w_is_dp    = (op == 2'b00);
    assign w_imm      = funct[5];
    assign w_cmd      = funct[4:1];
    assign w_s        = funct[0];
    assign w_u        = funct[3];
    assign w_l        = funct[0];
    assign w_rd_is_pc = (rd == RD_W'(PC_REG));

    // TST/TEQ/CMP/CMN occupy cmd 10xx and only update flags
    assign w_no_write_dec = w_is_dp & (w_cmd[3:2] == 2'b10);
    // MOV (1101) and MVN (1111)
    assign w_sh_src_dec   = w_is_dp & ((w_cmd == 4'b1101) | (w_cmd == 4'b1111));

    // Commands whose carry/overflow are meaningful
    always_comb begin
        w_arith = 1'b0;
        case (w_cmd)
            4'b0100, 4'b0101, 4'b0010, 4'b0110,
            4'b0011, 4'b0111, 4'b1010, 4'b1011: w_arith = 1'b1;
            default:                            w_arith = 1'b0;
        endcase
    end

    assign w_flags = {w_s & cond_ex, w_s & cond_ex & w_arith};

    // Wait-timeout: the current cycle would be the MAX_WAIT-th unanswered one
    logic w_mem_state;
    logic w_timeout;

    assign w_mem_state = (r_state == S_FETCH) | (r_state == S_MEMRD) | (r_state == S_MEMWR);
    assign w_timeout   = w_mem_state & ~mem_ready & (r_wait_cnt == CNT_W'(MAX_WAIT - 1));

    // Next-state selection
    always_comb begin
        w_next = r_state;
        case (r_state)
            S_FETCH:  if (mem_ready) w_next = S_DECODE;
            S_DECODE: begin
                case (op)
                    2'b00:   w_next = w_imm ? S_EXECI : S_EXECR;
                    2'b01:   w_next = S_MEMADR;
                    2'b10:   w_next = S_BRANCH;
                    default: w_next = S_FAULT;
                endcase
            end
            S_MEMADR: begin
                if (!cond_ex)  w_next = S_FETCH;
                else if (w_l)  w_next = S_MEMRD;
                else           w_next = S_MEMWR;
            end
            S_MEMRD:  if (mem_ready) w_next = S_MEMWB;
            S_MEMWR:  if (mem_ready) w_next = S_FETCH;
            S_MEMWB:  w_next = S_FETCH;
            S_EXECR:  w_next = S_ALUWB;
            S_EXECI:  w_next = S_ALUWB;
            S_ALUWB:  w_next = S_FETCH;
            S_BRANCH: w_next = S_FETCH;
            S_FAULT:  w_next = S_FAULT;
            default:  w_next = S_FAULT;
        endcase
        // A same-cycle mem_ready has already been excluded from w_timeout
        if (w_timeout) begin
            w_next = S_FAULT;
        end
    end

    // State, wait counter and sticky fault.
    // The counter is zero outside request states and after every completed
    // access, so entering FETCH/MEMRD/MEMWR always starts from zero.
    always_ff @(posedge clk) begin
        if (rst) begin
            r_state    <= S_FETCH;
            r_wait_cnt <= '0;
            r_fault    <= 1'b0;
        end else begin
            r_state <= w_next;
            if (w_mem_state && !mem_ready && !w_timeout) begin
                r_wait_cnt <= r_wait_cnt + CNT_W'(1);
            end else begin
                r_wait_cnt <= '0;
            end
            if (w_next == S_FAULT) begin
                r_fault <= 1'b1;
            end
        end
    end

    assign fault   = r_fault;
    assign state_o = r_state;

    // Output decode; everything is forced idle while rst is high
    always_comb begin
        mem_req     = 1'b0;
        mem_write   = 1'b0;
        adr_src     = 1'b0;
        ir_write    = 1'b0;
        pc_write    = 1'b0;
        reg_write   = 1'b0;
        alu_src_a   = 1'b0;
        alu_src_b   = 2'b00;
        result_src  = 2'b00;
        imm_src     = 2'b00;
        reg_src     = 2'b00;
        flag_write  = 2'b00;
        alu_control = ALU_ADD;
        no_write    = 1'b0;
        sh_src      = 1'b0;
        if (!rst) begin
            case (r_state)
                S_FETCH: begin
                    mem_req    = 1'b1;
                    alu_src_a  = 1'b1;
                    alu_src_b  = 2'b10;
                    result_src = 2'b10;
                    ir_write   = mem_ready;
                    pc_write   = mem_ready;
                end
                S_DECODE: begin
                    alu_src_a = 1'b1;
                    alu_src_b = 2'b10;
                    no_write  = w_no_write_dec;
                    sh_src    = w_sh_src_dec;
                end
                S_MEMADR: begin
                    alu_src_b   = 2'b01;
                    imm_src     = 2'b01;
                    alu_control = w_u ? ALU_ADD : ALU_SUB;
                end
                S_MEMRD: begin
                    mem_req = 1'b1;
                    adr_src = 1'b1;
                end
                S_MEMWR: begin
                    mem_req   = 1'b1;
                    mem_write = 1'b1;
                    adr_src   = 1'b1;
                    reg_src   = 2'b10;
                end
                S_MEMWB: begin
                    result_src = 2'b01;
                    pc_write   = w_rd_is_pc;
                    reg_write  = ~w_rd_is_pc;
                end
                S_EXECR: begin
                    alu_control = ALU_CTRL_W'(w_cmd);
                    // Immediate shift amount of MOV/MVN comes through the ext path
                    alu_src_b   = (w_sh_src_dec & sh_imm) ? 2'b01 : 2'b00;
                    flag_write  = w_flags;
                    no_write    = w_no_write_dec;
                    sh_src      = w_sh_src_dec;
                end
                S_EXECI: begin
                    alu_control = ALU_CTRL_W'(w_cmd);
                    alu_src_b   = 2'b01;
                    imm_src     = 2'b00;
                    flag_write  = w_flags;
                    no_write    = w_no_write_dec;
                    sh_src      = w_sh_src_dec;
                end
                S_ALUWB: begin
                    result_src = 2'b00;
                    no_write   = w_no_write_dec;
                    sh_src     = w_sh_src_dec;
                    if (!w_no_write_dec && cond_ex) begin
                        pc_write  = w_rd_is_pc;
                        reg_write = ~w_rd_is_pc;
                    end
                end
                S_BRANCH: begin
                    imm_src    = 2'b10;
                    reg_src    = 2'b01;
                    alu_src_b  = 2'b01;
                    result_src = 2'b10;
                    pc_write   = cond_ex;
                end
                default: begin
                end
            endcase
        end
    end

endmodule
